// File: rtl/alu_mdu.sv
// alu_mdu: EX-stage ALU (base ALUOp set) plus RV32M multiply/divide/remainder, valid/ready handshake.
// Latency: base ops and division special cases 1 cycle; mul/div WIDTH+1 cycles (mul 1 cycle with ALU_MDU_FASTMUL_EN).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; kill flushes to IDLE.
module alu_mdu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       alu_op,
   input  logic             is_m,
   input  logic [2:0]       m_funct3,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] PC,
   input  logic             kill,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] C,
   output logic             Zero
);

   // ALUOp encodings shared with the control unit
   localparam logic [4:0] op_lui   = 5'd1,  op_auipc = 5'd2,  op_add  = 5'd3,
                          op_sub   = 5'd4,  op_bne   = 5'd5,  op_blt  = 5'd6,
                          op_bge   = 5'd7,  op_bltu  = 5'd8,  op_bgeu = 5'd9,
                          op_slt   = 5'd10, op_sltu  = 5'd11, op_xor  = 5'd12,
                          op_or    = 5'd13, op_and   = 5'd14, op_sll  = 5'd15,
                          op_srl   = 5'd16, op_sra   = 5'd17;
   localparam logic [WIDTH-1:0] min_neg = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
   state_t state, state_nx;

   logic               accept, fast, last, lt_s, lt_u;
   logic               a_sgn, b_sgn, a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag, base_res, fast_res;
   // iteration state: opnd = multiplicand/divisor, {hi,lo} = accumulator / remainder:quotient
   logic [WIDTH-1:0]   opnd, hi, lo;
   logic [1:0]         f3_q;
   logic               neg_q, neg_r;
   logic [SHW-1:0]     cnt;
   logic [WIDTH:0]     msum, rsh, diff;
   logic [WIDTH-1:0]   hi_nx, lo_nx, quo, rmd, iter_res;
   logic [2*WIDTH-1:0] prod;
`ifdef ALU_MDU_FASTMUL_EN
   logic [2*WIDTH-1:0] fprod;
`endif

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && (state == IDLE) && !kill;
   assign last      = (cnt == SHW'(WIDTH-1));
   assign lt_s      = $signed(A) < $signed(B);
   assign lt_u      = A < B;

   // Base-op result from the live inputs; branch ops return 1 when the branch is not taken
   always_comb begin
      base_res = A;
      case (alu_op)
         op_lui:   base_res = B;
         op_auipc: base_res = PC + B;
         op_add:   base_res = A + B;
         op_sub:   base_res = A - B;
         op_bne:   base_res = WIDTH'(A == B);
         op_blt:   base_res = WIDTH'(!lt_s);
         op_bge:   base_res = WIDTH'(lt_s);
         op_bltu:  base_res = WIDTH'(!lt_u);
         op_bgeu:  base_res = WIDTH'(lt_u);
         op_slt:   base_res = WIDTH'(lt_s);
         op_sltu:  base_res = WIDTH'(lt_u);
         op_xor:   base_res = A ^ B;
         op_or:    base_res = A | B;
         op_and:   base_res = A & B;
         op_sll:   base_res = A << B[SHW-1:0];
         op_srl:   base_res = A >> B[SHW-1:0];
         op_sra:   base_res = $signed(A) >>> B[SHW-1:0];
         default:  base_res = A;
      endcase
   end

   // Operand sign/magnitude decode and selection of ops that finish at the accept edge
   always_comb begin
      a_sgn    = m_funct3[2] ? ~m_funct3[0] : (m_funct3[1:0] != 2'b11);
      b_sgn    = m_funct3[2] ? ~m_funct3[0] : ~m_funct3[1];
      a_neg    = a_sgn & A[WIDTH-1];
      b_neg    = b_sgn & B[WIDTH-1];
      a_mag    = a_neg ? -A : A;
      b_mag    = b_neg ? -B : B;
      fast     = 1'b1;
      fast_res = base_res;
`ifdef ALU_MDU_FASTMUL_EN
      fprod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
      if (a_neg ^ b_neg) fprod = -fprod;
`endif
      if (is_m) begin
         if (m_funct3[2]) begin
            if (B == '0)
               fast_res = m_funct3[1] ? A : '1;
            else if (!m_funct3[0] && A == min_neg && B == '1)
               fast_res = m_funct3[1] ? '0 : A;
            else
               fast = 1'b0;
         end else begin
`ifdef ALU_MDU_FASTMUL_EN
            fast_res = (m_funct3[1:0] == 2'b00) ? fprod[WIDTH-1:0] : fprod[2*WIDTH-1:WIDTH];
`else
            fast = 1'b0;
`endif
         end
      end
   end

   // One shift-add or restoring-divide step, with the sign fix-up used on the last step
   always_comb begin
      msum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
      rsh  = {hi, lo[WIDTH-1]};
      diff = rsh - {1'b0, opnd};
      if (state == MUL) begin
         hi_nx = msum[WIDTH:1];
         lo_nx = {msum[0], lo[WIDTH-1:1]};
      end else begin
         hi_nx = diff[WIDTH] ? rsh[WIDTH-1:0] : diff[WIDTH-1:0];
         lo_nx = {lo[WIDTH-2:0], ~diff[WIDTH]};
      end
      prod = neg_q ? -{hi_nx, lo_nx} : {hi_nx, lo_nx};
      quo  = neg_q ? -lo_nx : lo_nx;
      rmd  = neg_r ? -hi_nx : hi_nx;
      if (state == MUL)
         iter_res = (f3_q == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
      else
         iter_res = f3_q[1] ? rmd : quo;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic; kill abandons any busy or pending op
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     if (accept) state_nx = fast ? DONE : (m_funct3[2] ? DIV : MUL);
         MUL, DIV: if (kill) state_nx = IDLE; else if (last) state_nx = DONE;
         DONE:     if (kill || out_ready) state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   // Operand latch, iteration registers and registered result
   always_ff @(posedge clk) begin
      if (rst) begin
         opnd  <= '0;
         hi    <= '0;
         lo    <= '0;
         f3_q  <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         cnt   <= '0;
         C     <= '0;
         Zero  <= 1'b1;
      end else if (accept) begin
         f3_q <= m_funct3[1:0];
         cnt  <= '0;
         hi   <= '0;
         if (fast) begin
            C    <= fast_res;
            Zero <= (fast_res == '0);
         end else if (!m_funct3[2]) begin
            opnd  <= a_mag;
            lo    <= b_mag;
            neg_q <= a_neg ^ b_neg;
            neg_r <= 1'b0;
         end else begin
            opnd  <= b_mag;
            lo    <= a_mag;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
         end
      end else if ((state == MUL || state == DIV) && !kill) begin
         hi  <= hi_nx;
         lo  <= lo_nx;
         cnt <= cnt + 1'b1;
         if (last) begin
            C    <= iter_res;
            Zero <= (iter_res == '0);
         end
      end
   end

endmodule

// File: tb/tb_alu_mdu.sv
module tb_alu_mdu;

   localparam logic [4:0] op_add = 5'd3, op_sub = 5'd4, op_sra = 5'd17;
`ifdef ALU_MDU_FASTMUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, is_m, kill, out_valid, out_ready, Zero;
   logic [4:0]  alu_op;
   logic [2:0]  m_funct3;
   logic [31:0] A, B, PC, C;
   int          n_checks = 0;
   int          n_fails  = 0;

   alu_mdu #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .is_m(is_m), .m_funct3(m_funct3), .A(A), .B(B), .PC(PC),
      .kill(kill), .out_valid(out_valid), .out_ready(out_ready), .C(C), .Zero(Zero)
   );

   always #5 clk = ~clk;

   // Reference: base ALU ops from their arithmetic definitions
   function automatic logic [31:0] ref_base(input logic [4:0] op, input logic [31:0] a, b, pc);
      longint sa, sb, sh;
      logic   lt, ltu;
      sa  = $signed(a);
      sb  = $signed(b);
      lt  = sa < sb;
      ltu = a < b;
      case (op)
         5'd1:  return b;
         5'd2:  return pc + b;
         5'd3:  return a + b;
         5'd4:  return a - b;
         5'd5:  return 32'(a == b);
         5'd6:  return 32'(!lt);
         5'd7:  return 32'(lt);
         5'd8:  return 32'(!ltu);
         5'd9:  return 32'(ltu);
         5'd10: return 32'(lt);
         5'd11: return 32'(ltu);
         5'd12: return a ^ b;
         5'd13: return a | b;
         5'd14: return a & b;
         5'd15: return a << b[4:0];
         5'd16: return a >> b[4:0];
         5'd17: begin sh = sa >>> b[4:0]; return sh[31:0]; end
         default: return a;
      endcase
   endfunction

   // Reference: RV32M results via 64-bit integer arithmetic
   function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a, b);
      longint          sa, sb, q;
      longint unsigned ua, ub, p;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (f3)
         3'b000: begin p = sa * sb; return p[31:0]; end
         3'b001: begin p = sa * sb; return p[63:32]; end
         3'b010: begin p = sa * longint'(ub); return p[63:32]; end
         3'b011: begin p = ua * ub; return p[63:32]; end
         3'b100: begin if (b == 0) return 32'hFFFFFFFF; q = sa / sb; return q[31:0]; end
         3'b101: begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
         3'b110: begin if (b == 0) return a; q = sa % sb; return q[31:0]; end
         default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
      endcase
   endfunction

   function automatic int exp_lat(input logic m, input logic [2:0] f3, input logic [31:0] a, b);
      if (!m) return 1;
      if (!f3[2]) return MUL_LAT;
      if (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) return 1;
      return 33;
   endfunction

   // Issue one op from IDLE, scramble inputs after accept, wait (bounded) for out_valid
   task automatic run_op(input logic m, input logic [2:0] f3, input logic [4:0] op,
                         input logic [31:0] a, b, pc,
                         output logic [31:0] c, output logic z, output int lat, output bit busy_ok);
      @(negedge clk);
      in_valid = 1; is_m = m; m_funct3 = f3; alu_op = op; A = a; B = b; PC = pc; out_ready = 0;
      @(posedge clk);
      #1;
      in_valid = 0; A = $urandom; B = $urandom; PC = $urandom;
      alu_op = 5'($urandom); m_funct3 = 3'($urandom); is_m = 1'($urandom);
      lat = 0; busy_ok = 1;
      do begin
         @(negedge clk);
         lat++;
         if (!out_valid && in_ready) busy_ok = 0;
      end while (!out_valid && lat < 100);
      c = C; z = Zero;
   endtask

   task automatic release_result();
      out_ready = 1;
      @(posedge clk);
      #1 out_ready = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b1)  begin n_fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_checks++; if (C !== 32'h0)        begin n_fails++; $display("FAIL reset_C got %h want 0", C); end
      n_checks++; if (Zero !== 1'b1)      begin n_fails++; $display("FAIL reset_Zero got %b want 1", Zero); end
   endtask

   task automatic test_base_ops();
      logic [4:0]  ops[3] = '{op_add, op_sub, op_sra};
      logic [31:0] as[3]  = '{32'h7FFFFFFF, 32'd5, 32'h80000000};
      logic [31:0] bs[3]  = '{32'd1, 32'd5, 32'h24};
      logic [31:0] es[3]  = '{32'h80000000, 32'h0, 32'hF8000000};
      logic        zs[3]  = '{1'b0, 1'b1, 1'b0};
      logic [31:0] c, a, b, pc, e;
      logic        z;
      logic [4:0]  op;
      int          lat;
      bit          bo;
      for (int i = 0; i < 3; i++) begin
         run_op(0, 3'b000, ops[i], as[i], bs[i], 32'h0, c, z, lat, bo);
         n_checks++;
         if (c !== es[i] || z !== zs[i] || lat != 1) begin
            n_fails++;
            $display("FAIL base_dir%0d got C=%h Z=%b lat=%0d want C=%h Z=%b lat=1", i, c, z, lat, es[i], zs[i]);
         end
         release_result();
      end
      for (int i = 0; i < 60; i++) begin
         op = 5'($urandom_range(0, 31));
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
         pc = $urandom;
         e  = ref_base(op, a, b, pc);
         run_op(0, 3'b000, op, a, b, pc, c, z, lat, bo);
         n_checks++;
         if (c !== e || z !== (e == 0) || lat != 1) begin
            n_fails++;
            $display("FAIL base_rand op=%0d a=%h b=%h got C=%h Z=%b lat=%0d want C=%h Z=%b lat=1",
                     op, a, b, c, z, lat, e, (e == 0));
         end
         release_result();
      end
   endtask

   task automatic test_mdu_ops();
      logic [2:0]  fs[5] = '{3'b010, 3'b001, 3'b100, 3'b110, 3'b011};
      logic [31:0] as[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'd100, 32'hFFFFFFFF};
      logic [31:0] bs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFF};
      logic [31:0] es[5] = '{32'hFFFFFFFF, 32'h0, 32'hFFFFFFF2, 32'd2, 32'hFFFFFFFE};
      int          ls[5] = '{MUL_LAT, MUL_LAT, 33, 33, MUL_LAT};
      logic [31:0] c, a, b, e;
      logic [2:0]  f;
      logic        z;
      int          lat, el;
      bit          bo;
      for (int i = 0; i < 5; i++) begin
         run_op(1, fs[i], 5'd0, as[i], bs[i], 32'h0, c, z, lat, bo);
         n_checks++;
         if (c !== es[i] || z !== (es[i] == 0) || lat != ls[i] || !bo) begin
            n_fails++;
            $display("FAIL mdu_dir%0d got C=%h Z=%b lat=%0d busy_ok=%0d want C=%h lat=%0d busy_ok=1",
                     i, c, z, lat, bo, es[i], ls[i]);
         end
         release_result();
      end
      for (int i = 0; i < 40; i++) begin
         f = 3'($urandom);
         a = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'h0;
            1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            2: b = 32'($urandom_range(1, 20));
            3: b = -32'($urandom_range(1, 20));
            default: b = $urandom;
         endcase
         e  = ref_m(f, a, b);
         el = exp_lat(1, f, a, b);
         run_op(1, f, 5'd0, a, b, 32'h0, c, z, lat, bo);
         n_checks++;
         if (c !== e || z !== (e == 0) || lat != el || !bo) begin
            n_fails++;
            $display("FAIL mdu_rand f3=%0d a=%h b=%h got C=%h Z=%b lat=%0d busy_ok=%0d want C=%h lat=%0d",
                     f, a, b, c, z, lat, bo, e, el);
         end
         release_result();
      end
   endtask

   task automatic test_div_special();
      logic [2:0]  fs[6] = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110};
      logic [31:0] as[6] = '{32'd7, 32'd7, 32'h80000000, 32'h80000000, 32'hFFFFFFF0, 32'hFFFFFFF0};
      logic [31:0] bs[6] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
      logic [31:0] es[6] = '{32'hFFFFFFFF, 32'd7, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF0};
      logic [31:0] c;
      logic        z;
      int          lat;
      bit          bo;
      for (int i = 0; i < 6; i++) begin
         run_op(1, fs[i], 5'd0, as[i], bs[i], 32'h0, c, z, lat, bo);
         n_checks++;
         if (c !== es[i] || z !== (es[i] == 0) || lat != 1) begin
            n_fails++;
            $display("FAIL div_special%0d got C=%h Z=%b lat=%0d want C=%h lat=1", i, c, z, lat, es[i]);
         end
         release_result();
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] c;
      logic        z;
      int          lat;
      bit          bo;
      run_op(1, 3'b100, 5'd0, 32'd100, 32'hFFFFFFF9, 32'h0, c, z, lat, bo);
      n_checks++;
      if (c !== 32'hFFFFFFF2 || lat != 33) begin
         n_fails++; $display("FAIL bp_div got C=%h lat=%0d want C=fffffff2 lat=33", c, lat);
      end
      for (int i = 0; i < 10; i++) begin
         in_valid = 1; is_m = 0; alu_op = op_add; A = 32'd1; B = 32'd2;
         @(negedge clk);
         n_checks++;
         if (C !== 32'hFFFFFFF2 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL bp_hold cyc=%0d got C=%h out_valid=%b in_ready=%b want C=fffffff2 1 0",
                     i, C, out_valid, in_ready);
         end
      end
      out_ready = 1;
      @(posedge clk);
      #1 out_ready = 0;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fails++; $display("FAIL bp_release got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
      end
      @(posedge clk);
      #1 in_valid = 0;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || C !== 32'd3) begin
         n_fails++; $display("FAIL back_to_back got out_valid=%b C=%h want 1 00000003", out_valid, C);
      end
      release_result();
   endtask

   task automatic test_kill();
      logic [31:0] c;
      logic        z;
      int          lat;
      bit          bo, quiet;
      run_op(0, 3'b000, op_add, 32'd3, 32'd4, 32'h0, c, z, lat, bo);
      release_result();
      @(negedge clk);
      in_valid = 1; is_m = 1; m_funct3 = 3'b100; A = 32'd1000; B = 32'd3;
      @(posedge clk);
      #1 in_valid = 0;
      repeat (12) @(negedge clk);
      kill = 1;
      @(posedge clk);
      #1 kill = 0;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fails++; $display("FAIL kill_busy got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
      end
      quiet = 1;
      repeat (40) begin
         @(negedge clk);
         if (out_valid !== 1'b0 || C !== 32'd7) quiet = 0;
      end
      n_checks++;
      if (!quiet) begin
         n_fails++; $display("FAIL kill_discard got out_valid=%b C=%h want 0 00000007", out_valid, C);
      end
      run_op(1, 3'b101, 5'd0, 32'd50, 32'd5, 32'h0, c, z, lat, bo);
      n_checks++;
      if (c !== 32'd10 || lat != 33) begin
         n_fails++; $display("FAIL kill_divu got C=%h lat=%0d want C=0000000a lat=33", c, lat);
      end
      kill = 1; out_ready = 1;
      @(posedge clk);
      #1 kill = 0; out_ready = 0;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fails++; $display("FAIL kill_done got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset_midop();
      logic [31:0] c;
      logic        z;
      int          lat;
      bit          bo, quiet;
      @(negedge clk);
      in_valid = 1; is_m = 1; m_funct3 = 3'b000; A = 32'h12345678; B = 32'h9ABCDEF1;
      @(posedge clk);
      #1 in_valid = 0;
      repeat (5) @(negedge clk);
      rst = 1;
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || C !== 32'h0 || Zero !== 1'b1) begin
         n_fails++;
         $display("FAIL rst_midop got in_ready=%b out_valid=%b C=%h Zero=%b want 1 0 00000000 1",
                  in_ready, out_valid, C, Zero);
      end
      quiet = 1;
      repeat (40) begin
         @(negedge clk);
         if (out_valid !== 1'b0) quiet = 0;
      end
      n_checks++;
      if (!quiet) begin n_fails++; $display("FAIL rst_quiet got out_valid=%b want 0", out_valid); end
      run_op(1, 3'b011, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, c, z, lat, bo);
      n_checks++;
      if (c !== 32'hFFFFFFFE || lat != MUL_LAT) begin
         n_fails++; $display("FAIL rst_recover got C=%h lat=%0d want C=fffffffe lat=%0d", c, lat, MUL_LAT);
      end
      release_result();
   endtask

   initial begin
      rst = 1; in_valid = 0; out_ready = 0; kill = 0; is_m = 0;
      alu_op = '0; m_funct3 = '0; A = '0; B = '0; PC = '0;
      test_reset();
      test_base_ops();
      test_mdu_ops();
      test_div_special();
      test_backpressure();
      test_kill();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
